usb3_fifo_reader: RTL



---
 rtl/usb3_rd_pkg.sv | 17 +
 rtl/usb3_lat_pipe.sv | 20 ++
 rtl/usb3_fifo_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/usb3_rd_pkg.sv
// Shared definitions for the FX3 slave-FIFO read path: state codes and default
// burst geometry. ram_cache_bb decodes ST_READ from here as well.
package usb3_rd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ARM    = 4'd3,
      ST_SETTLE = 4'd4,
      ST_OE     = 4'd5,
      ST_READ   = 4'd6,
      ST_DRAIN  = 4'd7
   } rd_state_t;

   localparam int DEF_RD_LATENCY = 2;
   localparam int DEF_BURST_LEN  = 256;

endpackage

// File: rtl/usb3_lat_pipe.sv
// Shift register with synchronous flush; carries the read-issued bit through
// the FX3 read latency plus the data capture stage.
module usb3_lat_pipe #(
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             flush,
   input  logic             din,
   output logic [DEPTH-1:0] taps
);

   always_ff @(posedge clk) begin
      if (flush) begin
         taps <= '0;
      end else begin
         taps <= {taps[DEPTH-2:0], din};
      end
   end

endmodule

// File: rtl/usb3_fifo_reader.sv
// FX3 synchronous slave FIFO burst reader: sequences SLCS/SLOE/SLRD per packet
// and delivers captured words with a per-word valid to the cache.
module usb3_fifo_reader
   import usb3_rd_pkg::*;
#(
   parameter int         BURST_LEN  = DEF_BURST_LEN,
   parameter int         RD_LATENCY = DEF_RD_LATENCY,
   parameter logic [1:0] FIFO_ADDR  = 2'b11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        USB3_FLAGA,
   input  logic        USB3_FLAGB,
   input  logic [31:0] USB3_DQ,
   input  logic        cache_ready,
   output logic        USB3_SLCS_N,
   output logic        USB3_SLOE_N,
   output logic        USB3_SLRD_N,
   output logic [1:0]  USB3_A,
   output logic [3:0]  usb_rd_state,
   output logic [31:0] data,
   output logic        data_valid,
   output logic [8:0]  burst_words,
   output logic        short_burst
);

   localparam int         PIPE_DEPTH = RD_LATENCY + 1;
   localparam logic [8:0] LAST_BEAT  = 9'(BURST_LEN - 1);
   localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);

   rd_state_t             state;
   logic                  flaga_q;
   logic                  flagb_q;
   logic [8:0]            beat_cnt;
   logic [1:0]            drain_cnt;
   logic                  slrd_n_q;
   logic                  rd_issue;
   logic [PIPE_DEPTH-1:0] vld_taps;

   // A low registered FLAGB suppresses the strobe of the cycle it is seen in,
   // so the read that would overrun the watermark is never issued.
   assign rd_issue     = ~slrd_n_q & flagb_q;
   assign USB3_SLRD_N  = ~rd_issue;
   assign usb_rd_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         flaga_q     <= 1'b0;
         flagb_q     <= 1'b0;
         beat_cnt    <= '0;
         drain_cnt   <= '0;
         slrd_n_q    <= 1'b1;
         USB3_SLCS_N <= 1'b1;
         USB3_SLOE_N <= 1'b1;
         USB3_A      <= 2'b00;
         burst_words <= '0;
         short_burst <= 1'b0;
      end else begin
         flaga_q <= USB3_FLAGA;
         flagb_q <= USB3_FLAGB;
         unique case (state)
            ST_IDLE: begin
               if (flaga_q && cache_ready) begin
                  state       <= ST_ARM;
                  USB3_SLCS_N <= 1'b0;
                  USB3_A      <= FIFO_ADDR;
               end
            end
            ST_ARM: begin
               beat_cnt    <= '0;
               short_burst <= 1'b0;
               state       <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!flaga_q) begin
                  state       <= ST_IDLE;
                  USB3_SLCS_N <= 1'b1;
                  USB3_A      <= 2'b00;
               end else begin
                  state       <= ST_OE;
                  USB3_SLOE_N <= 1'b0;
               end
            end
            ST_OE: begin
               state    <= ST_READ;
               slrd_n_q <= 1'b0;
            end
            ST_READ: begin
               if (!flagb_q || beat_cnt == LAST_BEAT) begin
                  state       <= ST_DRAIN;
                  slrd_n_q    <= 1'b1;
                  burst_words <= beat_cnt;
                  drain_cnt   <= '0;
                  if (!flagb_q) begin
                     short_burst <= 1'b1;
                  end
               end else begin
                  beat_cnt <= beat_cnt + 9'd1;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state       <= ST_IDLE;
                  USB3_SLCS_N <= 1'b1;
                  USB3_SLOE_N <= 1'b1;
                  USB3_A      <= 2'b00;
               end else begin
                  drain_cnt <= drain_cnt + 2'd1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               slrd_n_q    <= 1'b1;
               USB3_SLCS_N <= 1'b1;
               USB3_SLOE_N <= 1'b1;
               USB3_A      <= 2'b00;
            end
         endcase
      end
   end

   usb3_lat_pipe #(
      .DEPTH(PIPE_DEPTH)
   ) u_vld_pipe (
      .clk   (clk),
      .flush (rst),
      .din   (rd_issue),
      .taps  (vld_taps)
   );

   assign data_valid = vld_taps[PIPE_DEPTH-1];

   // Capture on the edge that raises data_valid, so data holds between words.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (vld_taps[PIPE_DEPTH-2]) begin
         data <= USB3_DQ;
      end
   end

endmodule
